clockport_bridge: RTL and testbench

//  Amiga clock-port front end feeding the shared-register block (cp_* side).

---
 rtl/clockport_pkg.sv | 24 ++
 rtl/clockport_bridge_if.sv | 25 ++
 rtl/cp_strobe_sync.sv | 24 ++
 rtl/clockport_bridge.sv | 160 ++++++++++++++++
 tb/tb_clockport_bridge.sv | 393 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clockport_pkg.sv
`timescale 1ns/1ps
// Shared types and widths for the Amiga clock-port bridge.
package clockport_pkg;

    localparam int CP_ADDR_W = 4;
    localparam int CP_DATA_W = 4;
    localparam int CNT_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_QUAL_RD,
        ST_QUAL_WR,
        ST_RD_ISSUE,
        ST_RD_DRIVE,
        ST_WR_ISSUE,
        ST_RELEASE
    } cp_state_t;

    // Saturating increment: the filter/release counters must never wrap.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/clockport_bridge_if.sv
`timescale 1ns/1ps
// Clock-port strobes/address plus the register-block request/data signals.
interface clockport_bridge_if;
    import clockport_pkg::*;

    logic                 CP_RD_n;
    logic                 CP_WR_n;
    logic [CP_ADDR_W-1:0] CP_A;
    logic                 cp_read;
    logic                 cp_write;
    logic [CP_ADDR_W-1:0] cp_address;
    logic [CP_DATA_W-1:0] cp_out_cmem_in;
    logic [CP_DATA_W-1:0] cp_in_cmem_out;

    modport master (
        output CP_RD_n, CP_WR_n, CP_A, cp_in_cmem_out,
        input  cp_read, cp_write, cp_address, cp_out_cmem_in
    );

    modport slave (
        input  CP_RD_n, CP_WR_n, CP_A, cp_in_cmem_out,
        output cp_read, cp_write, cp_address, cp_out_cmem_in
    );

endinterface

// File: rtl/cp_strobe_sync.sv
`timescale 1ns/1ps
// Multi-flop synchroniser for one active-low strobe; resets to the idle (high) level.
module cp_strobe_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], async_in};
        end
    end

    assign sync_out = sync_reg[STAGES-1];

endmodule

// File: rtl/clockport_bridge.sv
`timescale 1ns/1ps
// Clock-port front end: qualifies async RD/WR strobes, issues one-cycle requests,
// and drives the read nibble back onto CP_D while the raw read strobe is low.
module clockport_bridge
    import clockport_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_CYCLES  = 4,
    parameter int RELEASE_CYCLES = 4
) (
    input  logic                 clk200,
    input  logic                 reset_n,
    clockport_bridge_if.slave    bus,
    inout  wire  [CP_DATA_W-1:0] CP_D
);

    localparam logic [CNT_W-1:0] FILTER_LAST  = CNT_W'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);

    logic [1:0] rst_pipe_reg;
    logic       rst_n_int;

    // Assert immediately, release on a clock edge.
    always_ff @(posedge clk200 or negedge reset_n) begin
        if (!reset_n) begin
            rst_pipe_reg <= '0;
        end else begin
            rst_pipe_reg <= {rst_pipe_reg[0], 1'b1};
        end
    end

    assign rst_n_int = rst_pipe_reg[1];

    logic rd_sync;
    logic wr_sync;

    cp_strobe_sync #(.STAGES(SYNC_STAGES)) u_rd_sync (
        .clk      (clk200),
        .rst_n    (rst_n_int),
        .async_in (bus.CP_RD_n),
        .sync_out (rd_sync)
    );

    cp_strobe_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (
        .clk      (clk200),
        .rst_n    (rst_n_int),
        .async_in (bus.CP_WR_n),
        .sync_out (wr_sync)
    );

    cp_state_t            state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [CP_ADDR_W-1:0] addr_reg, addr_next;
    logic [CP_DATA_W-1:0] wdata_reg, wdata_next;
    logic [CP_DATA_W-1:0] rdata_reg, rdata_next;
    logic                 drive_reg, drive_next;

    always_ff @(posedge clk200 or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            drive_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
            drive_reg <= drive_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        drive_next = drive_reg;
        unique case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (!rd_sync && wr_sync) begin
                    state_next = ST_QUAL_RD;
                end else if (!wr_sync && rd_sync) begin
                    state_next = ST_QUAL_WR;
                end
            end
            ST_QUAL_RD: begin
                if (rd_sync || !wr_sync) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg >= FILTER_LAST) begin
                    addr_next  = bus.CP_A;
                    state_next = ST_RD_ISSUE;
                end else begin
                    cnt_next = cnt_inc(cnt_reg);
                end
            end
            ST_QUAL_WR: begin
                if (wr_sync || !rd_sync) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg >= FILTER_LAST) begin
                    addr_next  = bus.CP_A;
                    wdata_next = CP_D;
                    state_next = ST_WR_ISSUE;
                end else begin
                    cnt_next = cnt_inc(cnt_reg);
                end
            end
            ST_RD_ISSUE: begin
                drive_next = 1'b0;
                state_next = ST_RD_DRIVE;
            end
            ST_RD_DRIVE: begin
                // Register block answers one cycle after cp_read; capture once.
                if (!drive_reg) begin
                    rdata_next = bus.cp_in_cmem_out;
                    drive_next = 1'b1;
                end
                if (rd_sync) begin
                    drive_next = 1'b0;
                    cnt_next   = '0;
                    state_next = ST_RELEASE;
                end
            end
            ST_WR_ISSUE: begin
                cnt_next   = '0;
                state_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (rd_sync && wr_sync) begin
                    if (cnt_reg >= RELEASE_LAST) begin
                        state_next = ST_IDLE;
                    end else begin
                        cnt_next = cnt_inc(cnt_reg);
                    end
                end else begin
                    cnt_next = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.cp_read        = (state_reg == ST_RD_ISSUE);
    assign bus.cp_write       = (state_reg == ST_WR_ISSUE);
    assign bus.cp_address     = addr_reg;
    assign bus.cp_out_cmem_in = wdata_reg;

    // Raw strobe term lets the bus go high-Z the instant the Amiga ends the cycle.
    logic drive_en;
    assign drive_en = reset_n && (state_reg == ST_RD_DRIVE) && drive_reg && !bus.CP_RD_n;
    assign CP_D     = drive_en ? rdata_reg : 'z;

endmodule

// File: tb/tb_clockport_bridge.sv
`timescale 1ns/1ps
// Scoreboard bench for clockport_bridge: strobe-level stimulus, pulse monitor, CP_D checks.
module tb_clockport_bridge;
    import clockport_pkg::*;

    typedef struct packed {
        logic        is_write;
        logic [3:0]  addr;
        logic [3:0]  data;
        logic [31:0] cycle;
    } txn_t;

    logic        clk200    = 1'b0;
    logic        reset_n   = 1'b0;
    logic [31:0] cycle_cnt = '0;
    int          compared    = 0;
    int          mismatched  = 0;
    int          overlap_cnt = 0;
    txn_t        exp_q[$];
    txn_t        obs_q[$];

    logic [3:0] tb_d    = 4'h0;
    logic       tb_d_en = 1'b0;
    wire  [3:0] cp_d;

    always #2.5 clk200 = ~clk200;
    always @(posedge clk200) cycle_cnt <= cycle_cnt + 32'd1;

    clockport_bridge_if bus ();

    assign cp_d = tb_d_en ? tb_d : 4'bzzzz;
    pullup pu0 (cp_d[0]);
    pullup pu1 (cp_d[1]);
    pullup pu2 (cp_d[2]);
    pullup pu3 (cp_d[3]);

    clockport_bridge #(
        .SYNC_STAGES    (2),
        .FILTER_CYCLES  (4),
        .RELEASE_CYCLES (4)
    ) dut (
        .clk200  (clk200),
        .reset_n (reset_n),
        .bus     (bus),
        .CP_D    (cp_d)
    );

    // Pulse monitor: every cp_read/cp_write cycle becomes an observed transaction.
    always @(negedge clk200) begin
        if (bus.cp_read && bus.cp_write) overlap_cnt++;
        if (bus.cp_read || bus.cp_write)
            obs_q.push_back(txn_t'{bus.cp_write, bus.cp_address,
                                   bus.cp_write ? bus.cp_out_cmem_in : 4'h0, cycle_cnt});
    end

    // Register-block model: returns addr ^ 4'hB one cycle after cp_read.
    initial begin : regblock_model
        logic [3:0] rd_addr;
        bus.cp_in_cmem_out = 4'h0;
        forever begin
            @(negedge clk200);
            if (bus.cp_read) begin
                rd_addr = bus.cp_address;
                @(posedge clk200);
                #1 bus.cp_in_cmem_out = rd_addr ^ 4'hB;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk200);
        #1;
    endtask

    task automatic test_reset();
        step(3);
        @(negedge clk200);
        compared++;
        if (cp_d !== 4'hF) begin
            mismatched++; $display("FAIL reset_cp_d got %h want f (released)", cp_d);
        end
        compared++;
        if ({bus.cp_read, bus.cp_write} !== 2'b00) begin
            mismatched++; $display("FAIL reset_pulses got rd=%b wr=%b want 0 0", bus.cp_read, bus.cp_write);
        end
        compared++;
        if (bus.cp_address !== 4'h0) begin
            mismatched++; $display("FAIL reset_address got %h want 0", bus.cp_address);
        end
        compared++;
        if (bus.cp_out_cmem_in !== 4'h0) begin
            mismatched++; $display("FAIL reset_wdata got %h want 0", bus.cp_out_cmem_in);
        end
        step(1);
        reset_n = 1'b1;
        step(6);
        compared++;
        if ({bus.cp_read, bus.cp_write, bus.cp_address, bus.cp_out_cmem_in} !== 10'h000) begin
            mismatched++;
            $display("FAIL post_reset_outputs got rd=%b wr=%b a=%h d=%h want all 0",
                     bus.cp_read, bus.cp_write, bus.cp_address, bus.cp_out_cmem_in);
        end
        compared++;
        if (obs_q.size() != 0) begin
            mismatched++; $display("FAIL post_reset_pulses got %0d want 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_write();
        logic [31:0] fall;
        txn_t o, e;
        bus.CP_A = 4'h3; tb_d = 4'hA; tb_d_en = 1'b1;
        step(1);
        fall = cycle_cnt; bus.CP_WR_n = 1'b0;
        exp_q.push_back(txn_t'{1'b1, 4'h3, 4'hA, fall + 32'd7});
        step(40);
        bus.CP_WR_n = 1'b1;
        step(2);
        tb_d_en = 1'b0; bus.CP_A = 4'hF;
        step(12);
        compared++;
        if (obs_q.size() != exp_q.size()) begin
            mismatched++; $display("FAIL write_count got %0d pulses want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL write_txn got w=%0b a=%h d=%h cyc=%0d want w=%0b a=%h d=%h cyc=%0d",
                         o.is_write, o.addr, o.data, o.cycle, e.is_write, e.addr, e.data, e.cycle);
            end else $display("txn write a=%h d=%h cyc=%0d ok", o.addr, o.data, o.cycle);
        end
        obs_q.delete(); exp_q.delete();
        compared++;
        if (bus.cp_address !== 4'h3 || bus.cp_out_cmem_in !== 4'hA) begin
            mismatched++; $display("FAIL write_hold got a=%h d=%h want a=3 d=a", bus.cp_address, bus.cp_out_cmem_in);
        end
    endtask

    task automatic test_glitch();
        logic [31:0] fall;
        txn_t o, e;
        bus.CP_A = 4'h7; tb_d = 4'hC; tb_d_en = 1'b1;
        step(1);
        bus.CP_WR_n = 1'b0;
        step(2);
        bus.CP_WR_n = 1'b1;
        step(20);
        compared++;
        if (obs_q.size() != 0) begin
            mismatched++; $display("FAIL glitch_pulses got %0d want 0", obs_q.size());
        end
        compared++;
        if (bus.cp_address !== 4'h3 || bus.cp_out_cmem_in !== 4'hA) begin
            mismatched++; $display("FAIL glitch_hold got a=%h d=%h want a=3 d=a", bus.cp_address, bus.cp_out_cmem_in);
        end
        obs_q.delete();
        // A full-length write right after shows the FSM went back to IDLE.
        fall = cycle_cnt; bus.CP_WR_n = 1'b0;
        exp_q.push_back(txn_t'{1'b1, 4'h7, 4'hC, fall + 32'd7});
        step(20);
        bus.CP_WR_n = 1'b1;
        step(12);
        tb_d_en = 1'b0;
        compared++;
        if (obs_q.size() != exp_q.size()) begin
            mismatched++; $display("FAIL glitch_followup_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL glitch_followup_txn got w=%0b a=%h d=%h cyc=%0d want w=%0b a=%h d=%h cyc=%0d",
                         o.is_write, o.addr, o.data, o.cycle, e.is_write, e.addr, e.data, e.cycle);
            end else $display("txn write a=%h d=%h cyc=%0d ok", o.addr, o.data, o.cycle);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_read(input logic [3:0] addr, input logic [3:0] want, input string tag);
        logic [31:0] fall;
        txn_t o, e;
        int bad;
        bus.CP_A = addr;
        step(1);
        fall = cycle_cnt; bus.CP_RD_n = 1'b0;
        exp_q.push_back(txn_t'{1'b0, addr, 4'h0, fall + 32'd7});
        repeat (8) @(posedge clk200);
        @(negedge clk200);
        compared++;
        if (cp_d !== 4'hF) begin
            mismatched++; $display("FAIL %s_early_drive got %h want f (released)", tag, cp_d);
        end
        @(negedge clk200);
        compared++;
        if (cp_d !== want) begin
            mismatched++; $display("FAIL %s_first_drive got %h want %h", tag, cp_d, want);
        end
        bad = 0;
        repeat (30) begin
            @(negedge clk200);
            if (cp_d !== want) bad++;
        end
        @(posedge clk200);
        #1 bus.CP_RD_n = 1'b1;
        #1;
        compared++;
        if (cp_d !== 4'hF) begin
            mismatched++; $display("FAIL %s_release got %h want f (released)", tag, cp_d);
        end
        compared++;
        if (bad != 0) begin
            mismatched++; $display("FAIL %s_hold got %0d bad cycles want 0", tag, bad);
        end
        step(12);
        compared++;
        if (obs_q.size() != exp_q.size()) begin
            mismatched++; $display("FAIL %s_count got %0d pulses want %0d", tag, obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL %s_txn got w=%0b a=%h cyc=%0d want w=%0b a=%h cyc=%0d",
                         tag, o.is_write, o.addr, o.cycle, e.is_write, e.addr, e.cycle);
            end else $display("txn read a=%h cyc=%0d ok", o.addr, o.cycle);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_both_low();
        int bad;
        bus.CP_A = 4'h9;
        step(1);
        bus.CP_RD_n = 1'b0; bus.CP_WR_n = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk200);
            if (cp_d !== 4'hF) bad++;
        end
        @(posedge clk200);
        #1 bus.CP_RD_n = 1'b1; bus.CP_WR_n = 1'b1;
        step(12);
        compared++;
        if (bad != 0) begin
            mismatched++; $display("FAIL both_low_cp_d got %0d driven cycles want 0", bad);
        end
        compared++;
        if (obs_q.size() != 0) begin
            mismatched++; $display("FAIL both_low_pulses got %0d want 0", obs_q.size());
        end
        compared++;
        if (bus.cp_address !== 4'hE) begin
            mismatched++; $display("FAIL both_low_hold got a=%h want e", bus.cp_address);
        end
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [31:0] f1, f2;
        txn_t o, e;
        // Short gap: the second low phase falls inside RELEASE and is absorbed.
        bus.CP_A = 4'h1; tb_d = 4'h6; tb_d_en = 1'b1;
        step(1);
        f1 = cycle_cnt; bus.CP_WR_n = 1'b0;
        exp_q.push_back(txn_t'{1'b1, 4'h1, 4'h6, f1 + 32'd7});
        step(20);
        bus.CP_WR_n = 1'b1; bus.CP_A = 4'h2; tb_d = 4'h9;
        step(2);
        bus.CP_WR_n = 1'b0;
        step(20);
        bus.CP_WR_n = 1'b1;
        step(12);
        compared++;
        if (obs_q.size() != exp_q.size()) begin
            mismatched++; $display("FAIL b2b_short_count got %0d pulses want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL b2b_short_txn got w=%0b a=%h d=%h cyc=%0d want w=%0b a=%h d=%h cyc=%0d",
                         o.is_write, o.addr, o.data, o.cycle, e.is_write, e.addr, e.data, e.cycle);
            end else $display("txn write a=%h d=%h cyc=%0d ok", o.addr, o.data, o.cycle);
        end
        obs_q.delete(); exp_q.delete();
        compared++;
        if (bus.cp_address !== 4'h1) begin
            mismatched++; $display("FAIL b2b_short_hold got a=%h want 1", bus.cp_address);
        end
        // Long gap: both accesses are accepted, each with full latency.
        f1 = cycle_cnt; bus.CP_WR_n = 1'b0;
        exp_q.push_back(txn_t'{1'b1, 4'h2, 4'h9, f1 + 32'd7});
        step(20);
        bus.CP_WR_n = 1'b1; bus.CP_A = 4'h4; tb_d = 4'hD;
        step(10);
        f2 = cycle_cnt; bus.CP_WR_n = 1'b0;
        exp_q.push_back(txn_t'{1'b1, 4'h4, 4'hD, f2 + 32'd7});
        step(20);
        bus.CP_WR_n = 1'b1;
        step(12);
        tb_d_en = 1'b0;
        compared++;
        if (obs_q.size() != exp_q.size()) begin
            mismatched++; $display("FAIL b2b_long_count got %0d pulses want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL b2b_long_txn got w=%0b a=%h d=%h cyc=%0d want w=%0b a=%h d=%h cyc=%0d",
                         o.is_write, o.addr, o.data, o.cycle, e.is_write, e.addr, e.data, e.cycle);
            end else $display("txn write a=%h d=%h cyc=%0d ok", o.addr, o.data, o.cycle);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] fall;
        txn_t o, e;
        bus.CP_A = 4'hE;
        step(1);
        fall = cycle_cnt; bus.CP_RD_n = 1'b0;
        exp_q.push_back(txn_t'{1'b0, 4'hE, 4'h0, fall + 32'd7});
        repeat (12) @(posedge clk200);
        @(negedge clk200);
        compared++;
        if (cp_d !== 4'h5) begin
            mismatched++; $display("FAIL rst_pre_drive got %h want 5", cp_d);
        end
        #1 reset_n = 1'b0;
        #1;
        compared++;
        if (cp_d !== 4'hF) begin
            mismatched++; $display("FAIL rst_cp_d got %h want f (released)", cp_d);
        end
        compared++;
        if ({bus.cp_read, bus.cp_write} !== 2'b00) begin
            mismatched++; $display("FAIL rst_pulses got rd=%b wr=%b want 0 0", bus.cp_read, bus.cp_write);
        end
        compared++;
        if (bus.cp_address !== 4'h0 || bus.cp_out_cmem_in !== 4'h0) begin
            mismatched++; $display("FAIL rst_regs got a=%h d=%h want 0 0", bus.cp_address, bus.cp_out_cmem_in);
        end
        @(posedge clk200);
        #1 bus.CP_RD_n = 1'b1;
        step(4);
        reset_n = 1'b1;
        step(6);
        compared++;
        if (obs_q.size() != exp_q.size()) begin
            mismatched++; $display("FAIL rst_count got %0d pulses want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL rst_txn got w=%0b a=%h cyc=%0d want w=%0b a=%h cyc=%0d",
                         o.is_write, o.addr, o.cycle, e.is_write, e.addr, e.cycle);
            end else $display("txn read a=%h cyc=%0d ok", o.addr, o.cycle);
        end
        obs_q.delete(); exp_q.delete();
        test_read(4'h2, 4'h9, "read_after_reset");
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation exceeded 200 us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.CP_RD_n = 1'b1;
        bus.CP_WR_n = 1'b1;
        bus.CP_A    = 4'h0;
        reset_n     = 1'b0;
        test_reset();
        test_write();
        test_glitch();
        test_read(4'hE, 4'h5, "read");
        test_both_low();
        test_back_to_back();
        test_reset_mid_read();
        compared++;
        if (overlap_cnt != 0) begin
            mismatched++; $display("FAIL rd_wr_overlap got %0d cycles want 0", overlap_cnt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
